hv_timing_ctrl: RTL

Synchronous horizontal/vertical timing sequencer for the arcade video path. It sequences the 9-bit horizontal counter: the loadable 8-bit counter plus the H8 extension bit, reloaded at terminal count. It also runs the companion vertical counter and derives registered blank/sync strobes. The load/terminal-count feedback is moved into one clocked domain, so correct operation does not depend on gate or flop delays. All video logic downstream (sprite/tile fetch, palette, DAC) consumes its counters and strobes.

---
 rtl/hv_timing_pkg.sv | 29 ++
 rtl/hv_timing_ctrl_window.sv | 21 ++
 rtl/hv_timing_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/hv_timing_pkg.sv
// -----------------------------------------------------------------------------
// hv_timing_pkg
// Shared constants and types for the horizontal/vertical timing sequencer.
//   CNT_W / CNT_MAX : counter width and terminal count (both axes)
//   H_START/V_START : reload values; a line is 512-H_START counts and a frame
//                     is 512-V_START lines
//   win_t           : a blank/sync window, asserted for on <= cnt < off
// -----------------------------------------------------------------------------
package hv_timing_pkg;

  localparam int CNT_W = 9;

  localparam logic [CNT_W-1:0] CNT_MAX = 9'h1FF;
  localparam logic [CNT_W-1:0] CNT_INC = 9'd1;

  localparam logic [CNT_W-1:0] H_START = 9'h0C0;
  localparam logic [CNT_W-1:0] V_START = 9'h0F8;

  typedef struct packed {
    logic [CNT_W-1:0] on;
    logic [CNT_W-1:0] off;
  } win_t;

  localparam win_t HB_WIN = '{on: 9'h0C0, off: 9'h100};
  localparam win_t HS_WIN = '{on: 9'h0D0, off: 9'h0F0};
  localparam win_t VB_WIN = '{on: 9'h0F8, off: 9'h110};
  localparam win_t VS_WIN = '{on: 9'h0FC, off: 9'h100};

endpackage

// File: rtl/hv_timing_ctrl_window.sv
// -----------------------------------------------------------------------------
// timing_window
// Pure combinational window compare: in_win_o = (on_i <= cnt_i < off_i),
// unsigned. on_i == off_i gives an empty window.
//   cnt_i    : counter value under test
//   on_i     : first count inside the window
//   off_i    : first count past the window
//   in_win_o : 1 while cnt_i is inside the window
// -----------------------------------------------------------------------------
module timing_window
  import hv_timing_pkg::*;
(
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [CNT_W-1:0] on_i,
  input  logic [CNT_W-1:0] off_i,
  output logic             in_win_o
);

  assign in_win_o = (cnt_i >= on_i) && (cnt_i < off_i);

endmodule

// File: rtl/hv_timing_ctrl.sv
// -----------------------------------------------------------------------------
// hv_timing_ctrl
// Horizontal/vertical timing sequencer for the arcade video path. Both counters
// run from H_START/V_START up to 9'h1FF and reload (never wrap through 0).
// Blank/sync levels are registered from the next-state counts so they change on
// the same edge as the counters they describe.
//
// Ports
//   clk         : master clock
//   rst_n       : asynchronous active-low reset
//   ce_pix      : pixel clock enable; nothing advances while low
//   sync_req    : frame restart request, held until sync_ack
//   sync_ack    : one-cycle strobe in the reload cycle that honours sync_req
//   hcnt, vcnt  : horizontal (bit 8 = H8) and vertical counts
//   hload       : terminal-count strobe (hcnt == 9'h1FF and ce_pix)
//   frame_start : strobe in the reload cycle that also reloads vcnt
//   hblank, vblank   : active-high blanking
//   hsync_n, vsync_n : active-low sync
//
// Handshake: sync_req is a level request. It is latched into a pending flag on
// any clk edge; the next hload cycle (including one coincident with the first
// sync_req cycle) forces vcnt to V_START, asserts sync_ack for that one cycle
// and clears the flag. The requester drops sync_req after seeing sync_ack.
// -----------------------------------------------------------------------------
module hv_timing_ctrl
  import hv_timing_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce_pix,
  input  logic             sync_req,
  output logic             sync_ack,
  output logic [CNT_W-1:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic             hload,
  output logic             frame_start,
  output logic             hblank,
  output logic             vblank,
  output logic             hsync_n,
  output logic             vsync_n
);

  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;
  logic             pend_q, pend_d;
  logic             hblank_q, vblank_q, hsync_n_q, vsync_n_q;

  logic             tc;        // terminal count in an enabled cycle
  logic             sync_due;  // a restart is owed at the next reload
  logic             hb_win, hs_win, vb_win, vs_win;

  // ---------------------------------------------------------------------------
  // Next-state counters and pending-sync flag
  // ---------------------------------------------------------------------------
  always_comb begin
    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;
    tc       = ce_pix && (hcnt_q == CNT_MAX);
    // A request seen in the reload cycle itself counts as already pending.
    sync_due = pend_q || sync_req;
    pend_d   = sync_due;

    if (ce_pix) begin
      if (hcnt_q == CNT_MAX) begin
        hcnt_d = H_START;
        if ((vcnt_q == CNT_MAX) || sync_due) begin
          vcnt_d = V_START;
        end else begin
          vcnt_d = vcnt_q + CNT_INC;
        end
        pend_d = 1'b0;
      end else begin
        hcnt_d = hcnt_q + CNT_INC;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Window compares on the next-state counts
  // ---------------------------------------------------------------------------
  timing_window u_hblank_win (
    .cnt_i    (hcnt_d),
    .on_i     (HB_WIN.on),
    .off_i    (HB_WIN.off),
    .in_win_o (hb_win)
  );

  timing_window u_hsync_win (
    .cnt_i    (hcnt_d),
    .on_i     (HS_WIN.on),
    .off_i    (HS_WIN.off),
    .in_win_o (hs_win)
  );

  timing_window u_vblank_win (
    .cnt_i    (vcnt_d),
    .on_i     (VB_WIN.on),
    .off_i    (VB_WIN.off),
    .in_win_o (vb_win)
  );

  timing_window u_vsync_win (
    .cnt_i    (vcnt_d),
    .on_i     (VS_WIN.on),
    .off_i    (VS_WIN.off),
    .in_win_o (vs_win)
  );

  // ---------------------------------------------------------------------------
  // State registers. With ce_pix low the next-state counts equal the current
  // ones, so the window levels hold without a separate enable.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q    <= H_START;
      vcnt_q    <= V_START;
      pend_q    <= 1'b0;
      hblank_q  <= 1'b1;
      vblank_q  <= 1'b1;
      hsync_n_q <= 1'b1;
      vsync_n_q <= 1'b1;
    end else begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      pend_q    <= pend_d;
      hblank_q  <= hb_win;
      vblank_q  <= vb_win;
      hsync_n_q <= ~hs_win;
      vsync_n_q <= ~vs_win;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. The strobes are all qualified by the enabled terminal-count
  // cycle, so none of them can appear while ce_pix is low.
  // ---------------------------------------------------------------------------
  assign hcnt        = hcnt_q;
  assign vcnt        = vcnt_q;
  assign hload       = tc;
  assign frame_start = tc && (vcnt_d == V_START);
  assign sync_ack    = tc && sync_due;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign hsync_n     = hsync_n_q;
  assign vsync_n     = vsync_n_q;

endmodule
